div_iter: RTL and testbench

- Sequential 64-bit radix-2 integer divider; the inverse companion of the combinational Booth/Wallace multiplier in the execute stage.
- Accepts a dividend/divisor pair through a valid/ready handshake and iterates one quotient bit per cycle.
- Returns quotient and remainder with RISC-V M-extension semantics (DIV/DIVU/REM/REMU), including the divide-by-zero and overflow cases.
- Supports a pipeline flush that aborts an in-flight operation.

---
 rtl/div_iter_if.sv | 31 +++
 rtl/div_iter.sv | 145 ++++++++++++++
 tb/tb_div_iter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if: handshake and data bundle for the iterative divider.
//   in_valid/in_ready   : operand handshake (producer -> divider)
//   dividend/divisor    : operands, WIDTH bits
//   sign                : 1 = signed, 0 = unsigned operation
//   flush               : abort the in-flight operation
//   out_valid/out_ready : result handshake (divider -> consumer)
//   quotient/remainder  : results, WIDTH bits
interface div_iter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             sign;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output in_valid, dividend, divisor, sign, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, dividend, divisor, sign, flush, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/div_iter.sv
// div_iter: sequential radix-2 restoring divider, one quotient bit per cycle.
// RISC-V M semantics: quotient rounds toward zero, remainder takes the sign
// of the dividend; divide-by-zero gives all-ones / dividend, signed overflow
// (MIN / -1) gives MIN / 0.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div_iter_if slave (operand/result handshakes, flush)
module div_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;        // dividend, shifts into quotient during CALC
  logic [WIDTH-1:0] b_q;        // divisor
  logic [WIDTH-1:0] r_q;        // partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   shift_w;
  logic             fits_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] a_abs_w;
  logic [WIDTH-1:0] b_abs_w;
  logic             ovf_w;

  always_comb begin
    shift_w = {r_q, a_q[WIDTH-1]};
    fits_w  = (shift_w >= {1'b0, b_q});
    // When the trial subtraction fits, the difference is below the divisor
    // and therefore representable in WIDTH bits.
    diff_w  = shift_w[WIDTH-1:0] - b_q;
    a_abs_w = (sign_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_abs_w = (sign_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    ovf_w   = sign_q && (a_q == MIN_NEG) && (b_q == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            a_q     <= bus.dividend;
            b_q     <= bus.divisor;
            sign_q  <= bus.sign;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            neg_q_q <= sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_r_q <= sign_q && a_q[WIDTH-1];
            if (b_q == '0) begin
              quotient_q  <= '1;
              remainder_q <= a_q;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (ovf_w) begin
              quotient_q  <= a_q;
              remainder_q <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              a_q     <= a_abs_w;
              b_q     <= b_abs_w;
              r_q     <= '0;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            r_q   <= fits_w ? diff_w : shift_w[WIDTH-1:0];
            a_q   <= {a_q[WIDTH-2:0], fits_w};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            quotient_q  <= neg_q_q ? (~a_q + 1'b1) : a_q;
            remainder_q <= neg_r_q ? (~r_q + 1'b1) : r_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands; returns after the acceptance edge (edge 0) + 1.
  task automatic start(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sg);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("start_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.sign     = sg;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Full operation: latency, results, optional backpressure, handshake.
  task automatic run(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                     input logic sg, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input int lat, input int stall);
    int n = 0;
    start(dvd, dvs, sg);
    while (n < 200) begin
      tick();
      n++;
      if (n == 1) check({tag, "_busy"}, {63'd0, bus.in_ready}, 64'd0);
      if (bus.out_valid) break;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_v"}, {63'd0, bus.out_valid}, 64'd1);
      check({tag, "_hold_rdy"}, {63'd0, bus.in_ready}, 64'd0);
      check({tag, "_hold_q"}, bus.quotient, eq);
      check({tag, "_hold_r"}, bus.remainder, er);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ack_v"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_ack_rdy"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.sign      = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_q", bus.quotient, 64'd0);
    check("rst_r", bus.remainder, 64'd0);

    run("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66, 0);
    run("s-7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run("s7_-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0);
    run("dz_u", 64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0);
    run("dz_s", 64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0);
    run("ovf_s", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
        64'h8000_0000_0000_0000, 64'd0, 1, 0);
    run("ovf_u", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
        64'd0, 64'h8000_0000_0000_0000, 66, 0);
    run("bp", 64'd1000, 64'd33, 1'b0, 64'd30, 64'd10, 66, 10);

    // Flush in IDLE together with in_valid: must not be accepted.
    bus.dividend = 64'd9;
    bus.divisor  = 64'd3;
    bus.sign     = 1'b0;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("idle_flush_rdy", {63'd0, bus.in_ready}, 64'd1);

    // Flush mid-CALC.
    start(64'd1000, 64'd3, 1'b0);
    tick();                      // edge 1: PREP -> CALC
    for (int i = 0; i < 30; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_rdy", {63'd0, bus.in_ready}, 64'd1);
    check("flush_v", {63'd0, bus.out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    run("post_flush", 64'd50, 64'd5, 1'b0, 64'd10, 64'd0, 66, 0);

    // Flush has priority over out_ready in DONE.
    start(64'h55, 64'd0, 1'b0);
    tick();
    check("fd_v", {63'd0, bus.out_valid}, 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("fd_gone", {63'd0, bus.out_valid}, 64'd0);
    check("fd_rdy", {63'd0, bus.in_ready}, 64'd1);

    // Async reset between edges during CALC.
    start(64'd777, 64'd5, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdy", {63'd0, bus.in_ready}, 64'd1);
    check("arst_v", {63'd0, bus.out_valid}, 64'd0);
    check("arst_q", bus.quotient, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0,
        64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 66, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
